// File: rtl/ad9911_pkg.sv
// Shared constants and state encoding for the AD9911 RF/LO frequency controller.
package ad9911_pkg;
  localparam logic [7:0] ADDR_FR1  = 8'h01;
  localparam logic [7:0] ADDR_CTW0 = 8'h04;

  localparam logic [5:0] LEN_FR1  = 6'd32;
  localparam logic [5:0] LEN_CTW0 = 6'd40;

  localparam int RWAIT_CYCLES = 16;

  localparam logic CHIP_RF = 1'b0;
  localparam logic CHIP_LO = 1'b1;

  typedef enum logic [2:0] {
    S_RST,
    S_RWAIT,
    S_INIT_RF,
    S_INIT_LO,
    S_IOU,
    S_IDLE,
    S_UPD_RF,
    S_UPD_LO
  } state_t;
endpackage

// File: rtl/ad9911_spi_shifter.sv
// Mode-0 SPI write shifter: sends the top len bits of a left-justified word to one
// of two chip selects, then pulses done as the chip select is released.
module ad9911_spi_shifter #(
  parameter int SCLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [39:0] word,
  input  logic [5:0]  len,
  input  logic        cs_sel,
  output logic        sclk,
  output logic        sdio,
  output logic        cs_rf_n,
  output logic        cs_lo_n,
  output logic        done,
  output logic        busy
);
  localparam logic [15:0] DIV_LAST = 16'(SCLK_DIV - 1);

  logic [39:0] shreg;
  logic [5:0]  bit_cnt;
  logic [15:0] div_cnt;

  // sclk doubles as the half-bit phase: low half first, shift at the end of the high half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sclk    <= 1'b0;
      cs_rf_n <= 1'b1;
      cs_lo_n <= 1'b1;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        busy    <= 1'b1;
        shreg   <= word;
        bit_cnt <= len - 6'd1;
        div_cnt <= '0;
        sclk    <= 1'b0;
        cs_rf_n <= cs_sel;
        cs_lo_n <= !cs_sel;
      end else if (busy) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          if (!sclk) begin
            sclk <= 1'b1;
          end else begin
            sclk <= 1'b0;
            if (bit_cnt == '0) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              cs_rf_n <= 1'b1;
              cs_lo_n <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt - 6'd1;
              shreg   <= {shreg[38:0], 1'b0};
            end
          end
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end
    end
  end

  assign sdio = busy & shreg[39];
endmodule

// File: rtl/ad9911_freq_ctrl.sv
// Sequences reset/FR1 init of the RF and LO AD9911 chips, then turns each accepted
// frequency request into RF and LO CTW0 writes followed by one shared IO_UPDATE pulse.
module ad9911_freq_ctrl
  import ad9911_pkg::*;
#(
  parameter int          SCLK_DIV        = 1,
  parameter logic [31:0] LO_OFFSET_FREQW = 32'h0,
  parameter logic [23:0] FR1_VALUE       = 24'hD00000,
  parameter int          RST_CYCLES      = 16,
  parameter int          IOU_CYCLES      = 4
) (
  input  logic        CLOCK_10M,
  input  logic        RESET_N,
  input  logic        UPDATE,
  input  logic [31:0] FREQW,
  output logic        INITIED,
  output logic        UPDATED,
  output logic        DDS_RESET,
  output logic        SCLK,
  output logic        SDIO,
  output logic        CS_RF_N,
  output logic        CS_LO_N,
  output logic        IO_UPDATE,
  output state_t      dbg_state
);
  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  // The cycle that issues the first FR1 start is the last of the idle cycles.
  localparam logic [15:0] RWAIT_LAST = 16'(RWAIT_CYCLES - 2);
  localparam logic [15:0] IOU_END    = 16'(IOU_CYCLES);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [31:0] rf_w, rf_w_n, lo_w, lo_w_n;
  logic        io_n, upd_n, init_n;
  logic        start, cs_sel, done, busy;
  logic [39:0] word;
  logic [5:0]  len;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rf_w_n  = rf_w;
    lo_w_n  = lo_w;
    io_n    = 1'b0;
    upd_n   = UPDATED;
    init_n  = INITIED;
    start   = 1'b0;
    cs_sel  = CHIP_RF;
    word    = {ADDR_FR1, FR1_VALUE, 8'h00};
    len     = LEN_FR1;
    case (state)
      S_RST: begin
        if (cnt == RST_LAST) begin
          state_n = S_RWAIT;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_RWAIT: begin
        if (cnt == RWAIT_LAST) begin
          state_n = S_INIT_RF;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_INIT_RF: begin
        start = !busy && !done;
        if (done) state_n = S_INIT_LO;
      end
      S_INIT_LO: begin
        cs_sel = CHIP_LO;
        start  = !busy && !done;
        if (done) state_n = S_IOU;
      end
      S_IOU: begin
        if (cnt == IOU_END) begin
          state_n = S_IDLE;
          cnt_n   = '0;
          upd_n   = 1'b1;
          init_n  = 1'b1;
        end else begin
          io_n  = 1'b1;
          cnt_n = cnt + 16'd1;
        end
      end
      S_IDLE: begin
        if (UPDATE) begin
          state_n = S_UPD_RF;
          rf_w_n  = FREQW;
          lo_w_n  = FREQW + LO_OFFSET_FREQW;
        end
      end
      S_UPD_RF: begin
        upd_n = 1'b0;
        word  = {ADDR_CTW0, rf_w};
        len   = LEN_CTW0;
        start = !busy && !done;
        if (done) state_n = S_UPD_LO;
      end
      S_UPD_LO: begin
        cs_sel = CHIP_LO;
        word   = {ADDR_CTW0, lo_w};
        len    = LEN_CTW0;
        start  = !busy && !done;
        if (done) state_n = S_IOU;
      end
      default: state_n = S_RST;
    endcase
  end

  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_RST;
      cnt       <= '0;
      rf_w      <= '0;
      lo_w      <= '0;
      IO_UPDATE <= 1'b0;
      UPDATED   <= 1'b0;
      INITIED   <= 1'b0;
      DDS_RESET <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rf_w      <= rf_w_n;
      lo_w      <= lo_w_n;
      IO_UPDATE <= io_n;
      UPDATED   <= upd_n;
      INITIED   <= init_n;
      DDS_RESET <= (state_n == S_RST);
    end
  end

  assign dbg_state = state;

  ad9911_spi_shifter #(.SCLK_DIV(SCLK_DIV)) u_shifter (
    .clk     (CLOCK_10M),
    .rst_n   (RESET_N),
    .start   (start),
    .word    (word),
    .len     (len),
    .cs_sel  (cs_sel),
    .sclk    (SCLK),
    .sdio    (SDIO),
    .cs_rf_n (CS_RF_N),
    .cs_lo_n (CS_LO_N),
    .done    (done),
    .busy    (busy)
  );
endmodule

// File: tb/tb_ad9911_freq_ctrl.sv
// Bench for ad9911_freq_ctrl: a fast instance (SCLK_DIV=1) and a slow one (SCLK_DIV=3),
// with a bus monitor that decodes SPI frames and compares them against an expected queue.
module tb_ad9911_freq_ctrl;
  import ad9911_pkg::*;

  localparam logic [31:0] OFF0 = 32'h01000000;
  localparam logic [31:0] OFF1 = 32'h00000020;
  localparam int          DIV0 = 1;
  localparam int          DIV1 = 3;

  typedef struct {
    logic [31:0] freqw;
    logic [39:0] rf_frame;
    logic [39:0] lo_frame;
  } vec_t;

  logic        clk = 1'b0;
  logic [1:0]  rst_n, update;
  logic [31:0] fw[2];
  logic [1:0]  initied, updated, dds_reset, sclk, sdio, cs_rf_n, cs_lo_n, io_update;
  state_t      state0, state1;

  always #50 clk = ~clk;

  ad9911_freq_ctrl #(.SCLK_DIV(DIV0), .LO_OFFSET_FREQW(OFF0)) dut0 (
    .CLOCK_10M(clk), .RESET_N(rst_n[0]), .UPDATE(update[0]), .FREQW(fw[0]),
    .INITIED(initied[0]), .UPDATED(updated[0]), .DDS_RESET(dds_reset[0]),
    .SCLK(sclk[0]), .SDIO(sdio[0]), .CS_RF_N(cs_rf_n[0]), .CS_LO_N(cs_lo_n[0]),
    .IO_UPDATE(io_update[0]), .dbg_state(state0)
  );

  ad9911_freq_ctrl #(.SCLK_DIV(DIV1), .LO_OFFSET_FREQW(OFF1)) dut1 (
    .CLOCK_10M(clk), .RESET_N(rst_n[1]), .UPDATE(update[1]), .FREQW(fw[1]),
    .INITIED(initied[1]), .UPDATED(updated[1]), .DDS_RESET(dds_reset[1]),
    .SCLK(sclk[1]), .SDIO(sdio[1]), .CS_RF_N(cs_rf_n[1]), .CS_LO_N(cs_lo_n[1]),
    .IO_UPDATE(io_update[1]), .dbg_state(state1)
  );

  int          errors = 0;
  int          checks = 0;
  logic [47:0] exp_q[$];

  bit          in_frame[2], fchip[2], half_ok[2], skip[2], psclk[2], pio[2];
  bit          both_low_bad[2], idle_sclk_bad[2];
  int          fbits[2], fcyc[2], run[2], io_run[2], io_cnt[2];
  logic [39:0] fdata[2];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int div_of(input int g);
    return (g == 0) ? DIV0 : DIV1;
  endfunction

  task automatic push_frame(input int g, input bit chip, input logic [5:0] len, input logic [39:0] data);
    exp_q.push_back({g[0], chip, len, data});
  endtask

  task automatic push_init(input int g);
    push_frame(g, 1'b0, 6'd32, 40'h0001D00000);
    push_frame(g, 1'b1, 6'd32, 40'h0001D00000);
  endtask

  task automatic end_frame(input int g);
    logic [47:0] a, e;
    if (skip[g]) begin
      skip[g] = 1'b0;
      return;
    end
    a = {g[0], fchip[g], 6'(fbits[g]), fdata[g]};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got %0h, expected no frame", a);
    end else begin
      e = exp_q.pop_front();
      check("frame", a, e);
      check("cs_low_cycles", fcyc[g], 2 * div_of(g) * int'(e[45:40]));
      check("sclk_half_period", half_ok[g], 1);
    end
  endtask

  // Decodes both buses on the falling clock edge, away from the DUT's active edge.
  task automatic monitor();
    bit rf_l, lo_l;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        rf_l = !cs_rf_n[g];
        lo_l = !cs_lo_n[g];
        if (rf_l && lo_l) both_low_bad[g] = 1'b1;
        if (!rf_l && !lo_l && sclk[g]) idle_sclk_bad[g] = 1'b1;
        if (rf_l || lo_l) begin
          if (!in_frame[g]) begin
            in_frame[g] = 1'b1;
            fchip[g]    = lo_l;
            fbits[g]    = 0;
            fcyc[g]     = 0;
            fdata[g]    = '0;
            run[g]      = 0;
            half_ok[g]  = 1'b1;
            psclk[g]    = 1'b0;
          end
          fcyc[g]++;
          if (sclk[g] != psclk[g]) begin
            if (run[g] != div_of(g)) half_ok[g] = 1'b0;
            run[g] = 1;
            if (sclk[g]) begin
              fdata[g] = {fdata[g][38:0], sdio[g]};
              fbits[g]++;
            end
          end else begin
            run[g]++;
          end
          psclk[g] = sclk[g];
        end else if (in_frame[g]) begin
          in_frame[g] = 1'b0;
          if (run[g] != div_of(g)) half_ok[g] = 1'b0;
          end_frame(g);
        end
        if (io_update[g] && !pio[g]) begin
          io_cnt[g]++;
          io_run[g] = 0;
        end
        if (io_update[g]) io_run[g]++;
        if (!io_update[g] && pio[g]) check("iou_width", io_run[g], 4);
        pio[g] = io_update[g];
      end
    end
  endtask

  // Call right after releasing reset on a falling edge; edge 1 is the next rising edge.
  task automatic measure_init(input int g, input int drop_update_at,
                              output int e_dds, output int e_cs, output int e_init);
    e_dds = -1; e_cs = -1; e_init = -1;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk); #1;
      if (k == drop_update_at) update[g] = 1'b0;
      if (e_dds < 0 && !dds_reset[g]) e_dds = k;
      if (e_cs < 0 && !cs_rf_n[g]) e_cs = k;
      if (initied[g]) begin
        e_init = k;
        break;
      end
    end
  endtask

  // UPDATE is high for edges 0 and 1; optional re-raise and FREQW change mid-transaction.
  task automatic run_txn(input int g, input logic [31:0] freqw, input int reraise_at,
                         input int fw_change_at, output int e_fall, output int e_rf,
                         output int e_lo, output int e_io, output int e_rise);
    e_fall = -1; e_rf = -1; e_lo = -1; e_io = -1; e_rise = -1;
    @(negedge clk);
    fw[g]     = freqw;
    update[g] = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(posedge clk); #1;
      if (k == 1) update[g] = 1'b0;
      if (k == reraise_at) update[g] = 1'b1;
      if (k == reraise_at + 2) update[g] = 1'b0;
      if (k == fw_change_at) fw[g] = ~freqw;
      if (e_fall < 0 && !updated[g]) e_fall = k;
      if (e_rf < 0 && !cs_rf_n[g]) e_rf = k;
      if (e_lo < 0 && !cs_lo_n[g]) e_lo = k;
      if (e_io < 0 && io_update[g]) e_io = k;
      if (e_fall >= 0 && updated[g]) begin
        e_rise = k;
        break;
      end
    end
  endtask

  initial begin
    vec_t vecs[5];
    int   e_dds, e_cs, e_init, e_fall, e_rf, e_lo, e_io, e_rise, io0;

    vecs[0] = '{32'h12345678, 40'h0412345678, 40'h0413345678};
    vecs[1] = '{32'hFFFFFFF0, 40'h04FFFFFFF0, 40'h0400FFFFF0};
    vecs[2] = '{32'h00000000, 40'h0400000000, 40'h0401000000};
    vecs[3] = '{32'hA5A5A5A5, 40'h04A5A5A5A5, 40'h04A6A5A5A5};
    vecs[4] = '{32'hFF123456, 40'h04FF123456, 40'h0400123456};

    rst_n  = 2'b00;
    update = 2'b00;
    fw[0]  = '0;
    fw[1]  = '0;
    fork
      monitor();
    join_none

    // Clock/reset
    repeat (5) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++)
      check("reset_outputs",
            {dds_reset[g], cs_rf_n[g], cs_lo_n[g], sclk[g], sdio[g], io_update[g], initied[g], updated[g]},
            8'b1110_0000);

    // Init sequence of the fast instance
    push_init(0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    measure_init(0, -1, e_dds, e_cs, e_init);
    check("init_dds_fall_edge", e_dds, 16);
    check("init_first_cs_edge", e_cs, 32);
    check("init_initied_edge", e_init, 168);
    check("init_updated", updated[0], 1);
    check("init_idle_state", state0, S_IDLE);

    // Table-driven update transactions
    for (int i = 0; i < 5; i++) begin
      push_frame(0, 1'b0, 6'd40, vecs[i].rf_frame);
      push_frame(0, 1'b1, 6'd40, vecs[i].lo_frame);
      run_txn(0, vecs[i].freqw, -1, -1, e_fall, e_rf, e_lo, e_io, e_rise);
      check($sformatf("v%0d_updated_fall", i), e_fall, 1);
      check($sformatf("v%0d_cs_rf_edge", i), e_rf, 1);
      check($sformatf("v%0d_cs_lo_edge", i), e_lo, 83);
      check($sformatf("v%0d_io_update_edge", i), e_io, 165);
      check($sformatf("v%0d_updated_rise", i), e_rise, 169);
      repeat (5) @(posedge clk);
    end

    // UPDATE during the LO frame is ignored; FREQW change after acceptance has no effect
    io0 = io_cnt[0];
    push_frame(0, 1'b0, 6'd40, 40'h040BADF00D);
    push_frame(0, 1'b1, 6'd40, 40'h040CADF00D);
    run_txn(0, 32'h0BADF00D, 100, 10, e_fall, e_rf, e_lo, e_io, e_rise);
    check("busy_req_updated_rise", e_rise, 169);
    repeat (400) @(posedge clk);
    #1;
    check("busy_req_no_extra_frame", exp_q.size(), 0);
    check("busy_req_one_io_pulse", io_cnt[0] - io0, 1);
    check("busy_req_idle", {updated[0], state0}, {1'b1, S_IDLE});

    // Reset mid RF frame aborts it and re-runs init; UPDATE during init is ignored
    @(negedge clk);
    fw[0]     = 32'h55AA55AA;
    update[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    update[0] = 1'b0;
    repeat (38) @(posedge clk);
    #2;
    check("mid_frame_cs_low", cs_rf_n[0], 0);
    skip[0] = 1'b1;
    exp_q.delete();
    rst_n[0] = 1'b0;
    #1;
    check("abort_outputs", {cs_rf_n[0], cs_lo_n[0], initied[0], updated[0], dds_reset[0]}, 5'b11001);
    repeat (3) @(negedge clk);
    push_init(0);
    update[0] = 1'b1;
    rst_n[0]  = 1'b1;
    measure_init(0, 100, e_dds, e_cs, e_init);
    check("reinit_dds_fall_edge", e_dds, 16);
    check("reinit_initied_edge", e_init, 168);
    repeat (50) @(posedge clk);
    #1;
    check("reinit_no_update_frames", exp_q.size(), 0);
    check("reinit_idle", {updated[0], state0}, {1'b1, S_IDLE});

    // Slow instance: SCLK_DIV=3 timing and LO tuning-word wrap
    push_init(1);
    @(negedge clk);
    rst_n[1] = 1'b1;
    measure_init(1, -1, e_dds, e_cs, e_init);
    check("div3_init_dds_fall_edge", e_dds, 16);
    check("div3_init_first_cs_edge", e_cs, 32);
    check("div3_init_initied_edge", e_init, 424);
    check("div3_idle_state", state1, S_IDLE);
    push_frame(1, 1'b0, 6'd40, 40'h04FFFFFFF0);
    push_frame(1, 1'b1, 6'd40, 40'h0400000010);
    run_txn(1, 32'hFFFFFFF0, -1, -1, e_fall, e_rf, e_lo, e_io, e_rise);
    check("div3_updated_fall", e_fall, 1);
    check("div3_cs_rf_edge", e_rf, 1);
    check("div3_cs_lo_edge", e_lo, 243);
    check("div3_io_update_edge", e_io, 485);
    check("div3_updated_rise", e_rise, 489);
    repeat (20) @(posedge clk);

    // Final report
    #1;
    check("one_cs_at_a_time", {both_low_bad[1], both_low_bad[0]}, 0);
    check("sclk_low_when_idle", {idle_sclk_bad[1], idle_sclk_bad[0]}, 0);
    check("exp_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ad9911_freq_ctrl.md
# ad9911_freq_ctrl

Sequences the two AD9911 DDS chips, RF and LO, that share one 3-wire SPI bus. After reset it runs a chip-reset and FR1 init sequence, then raises INITIED. Each UPDATE/FREQW request from the signal transceiver becomes a CTW0 write to the RF chip, a CTW0 write to the LO chip at an offset frequency, and one shared IO_UPDATE pulse. It owns the SPI bus and the frequency-update handshake; the transceiver never touches the chips directly.

## Interface
Parameters:
- SCLK_DIV, 1: CLOCK_10M cycles per SCLK half-period (1 gives a 5 MHz SCLK).
- LO_OFFSET_FREQW, 32'h0: tuning word added to FREQW for the LO chip.
- FR1_VALUE, 24'hD00000: FR1 payload written at init (PLL multiplier, VCO gain).
- RST_CYCLES, 16: DDS_RESET high time after RESET_N release.
- IOU_CYCLES, 4: IO_UPDATE high time.

Ports:
- CLOCK_10M, in, 1: system clock.
- RESET_N, in, 1: reset, asynchronous, active-low.
- UPDATE, in, 1: frequency update request, level sampled.
- FREQW, in, 32: RF tuning word, latched on acceptance.
- INITIED, out, 1: init sequence complete.
- UPDATED, out, 1: high when idle and the last write has completed.
- DDS_RESET, out, 1: MASTER_RESET to both chips.
- SCLK, out, 1: SPI clock, shared by both chips.
- SDIO, out, 1: SPI data, shared by both chips.
- CS_RF_N, out, 1: RF chip select.
- CS_LO_N, out, 1: LO chip select.
- IO_UPDATE, out, 1: shared IO_UPDATE.

## Operation
- Reset values:
  - DDS_RESET=1.
  - CS_RF_N=1, CS_LO_N=1.
  - SCLK=0, SDIO=0, IO_UPDATE=0.
  - INITIED=0, UPDATED=0.
- RESET_N low at any time has these effects immediately:
  - Any frame in progress is aborted.
  - Chip selects go high.
  - The controller re-enters S_RST.
- States and transitions:
  - S_RST: DDS_RESET high for RST_CYCLES, then low, then go to S_RWAIT.
  - S_RWAIT: idle for 16 cycles, then go to S_INIT_RF.
  - S_INIT_RF: FR1 frame to RF (address 0x01, 24-bit FR1_VALUE).
  - S_INIT_LO: same FR1 frame to LO.
  - S_IOU: IO_UPDATE pulse. On exit, set INITIED=1 and UPDATED=1, then go to S_IDLE.
  - S_IDLE: while UPDATE is high, accept the request:
    - latch rf_w=FREQW and lo_w=FREQW+LO_OFFSET_FREQW (mod 2^32, wraps silently);
    - set UPDATED=0;
    - go to S_UPD_RF.
  - S_UPD_RF: CTW0 frame to RF (address 0x04, 32-bit rf_w).
  - S_UPD_LO: CTW0 frame to LO (address 0x04, 32-bit lo_w).
  - Then S_IOU; on exit set UPDATED=1 and return to S_IDLE.
- UPDATE handling outside S_IDLE:
  - UPDATE outside S_IDLE is ignored; there is no queue.
  - FREQW changes after acceptance have no effect.
  - UPDATE before INITIED is ignored.
  - UPDATE still high on return to S_IDLE is accepted again. The requester must drop UPDATE once UPDATED falls.
- Frame format:
  - The instruction byte is the register address with the write bit (bit 7) = 0, sent MSB first, followed by the payload MSB first.
  - Length is 40 bits for CTW0 and 32 bits for FR1.
  - SPI mode 0.
- Only one chip select is low at a time. The controller is the sole bus master.

## Timing
- Bit timing:
  - Each bit is held on SDIO for 2·SCLK_DIV cycles.
  - SCLK is low for the first half of each bit and high for the second half.
  - SDIO changes only while SCLK is low.
- Chip select:
  - CS is low for exactly 2·SCLK_DIV·N cycles for an N-bit frame.
  - SDIO carries the MSB from the first CS-low cycle.
  - CS is high for at least 2 cycles between frames.
  - SCLK=0 whenever both chip selects are high.
- Update latency (SCLK_DIV=1, IOU_CYCLES=4), with UPDATE sampled at edge 0:
  - Cycles 1–80: CS_RF_N low.
  - Cycles 81–82: idle.
  - Cycles 83–162: CS_LO_N low.
  - Cycles 163–164: idle.
  - Cycles 165–168: IO_UPDATE high.
  - UPDATED=1 from cycle 169.
- UPDATED falls at edge 1, so a requester that drops UPDATE after seeing UPDATED low sees no stale completion.
- Init latency (defaults): 16 + 16 + 64 + 2 + 64 + 2 + 4 cycles after RESET_N release, then INITIED=1.

## Structure
- Package ad9911_pkg holds:
  - register addresses ADDR_FR1=8'h01 and ADDR_CTW0=8'h04;
  - the state enum;
  - frame lengths 32 and 40.
- Sub-module ad9911_spi_shifter. Inputs: start, 40-bit left-justified word, length, chip select. Outputs: SCLK, SDIO, CS, done pulse.
- The top level is the sequencing FSM plus request latch and adder.

## Test plan
- Reset release → DDS_RESET high 16 cycles, then two FR1 frames each carrying 0x01D00000, then one 4-cycle IO_UPDATE pulse, then INITIED=1 and UPDATED=1.
- UPDATE for 2 cycles with FREQW=32'h12345678 and LO_OFFSET=32'h01000000 → RF frame 0x0412345678, LO frame 0x0413345678, UPDATED low at cycle 1 and high at cycle 169.
- FREQW=32'hFFFFFFF0 with offset 32'h20 → LO payload 32'h00000010 (wrap).
- UPDATE asserted during the LO frame → no extra frame, exactly one IO_UPDATE pulse.
- RESET_N pulsed low mid RF frame → CS_RF_N high immediately, INITIED=0, full init re-run.
- SCLK_DIV=3 → SCLK half-period of 3 cycles, CTW0 frame CS-low for 240 cycles.
